// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), derived bounds and FSM encoding.
// Optional macro VGA_SYNC_ACTIVE_LOW_EN (used in vga_timing_ctrl) selects sync polarity.
package vga_timing_pkg;

  function automatic int axis_total(input int sync_w, input int bp, input int act, input int fp);
    return sync_w + bp + act + fp;
  endfunction

  localparam int DEF_CNT_W    = 10;
  localparam int DEF_PX_DIV   = 4;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;

  localparam int DEF_H_TOTAL     = axis_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
  localparam int DEF_V_TOTAL     = axis_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);
  localparam int DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_H_ACT_END   = DEF_H_ACT_START + DEF_H_ACTIVE;
  localparam int DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_V_ACT_END   = DEF_V_ACT_START + DEF_V_ACTIVE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis counter: counts 0..TOTAL-1 on i_en, flags the wrapping step.
module vga_axis_cnt #(
  parameter int TOTAL = 800,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign o_wrap = i_en && (cnt_q == LAST);
  assign o_cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)       cnt_d = '0;
    else if (o_wrap) cnt_d = '0;
    else if (i_en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: pixel enable, h/v sequencing, sync/DE/coords, run/drain FSM.
// Macro VGA_SYNC_ACTIVE_LOW_EN makes hsync/vsync active-low (idle level 1).
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int PX_DIV   = DEF_PX_DIV,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_run,
  output logic             o_px_en,
  output logic             o_vga_hsync,
  output logic             o_vga_vsync,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_frame_start,
  output logic             o_busy
);

  localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int DIV_W   = (PX_DIV > 1) ? $clog2(PX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PX_DIV - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S  = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_ACT_E  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_S  = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_ACT_E  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             busy, px_en, h_wrap, v_wrap;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             hs_act, vs_act, h_vis, v_vis, de;

  assign busy  = (state_q != ST_IDLE);
  assign px_en = busy && (div_q == DIV_LAST);
  assign div_d = (!busy || px_en) ? '0 : div_q + 1'b1;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  // v_wrap is the px_en of the last pixel in the frame: the only place DRAIN may stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_run) state_d = ST_RUN;
      ST_RUN:   if (!i_run) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (i_run)       state_d = ST_RUN;
        else if (v_wrap) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  vga_axis_cnt #(.TOTAL(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_clr  (!busy),
    .i_en   (px_en),
    .o_cnt  (h_cnt),
    .o_wrap (h_wrap)
  );

  vga_axis_cnt #(.TOTAL(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_clr  (!busy),
    .i_en   (h_wrap),
    .o_cnt  (v_cnt),
    .o_wrap (v_wrap)
  );

  always_comb begin
    hs_act = busy && (h_cnt < H_SYNC_E);
    vs_act = busy && (v_cnt < V_SYNC_E);
    h_vis  = (h_cnt >= H_ACT_S) && (h_cnt < H_ACT_E);
    v_vis  = (v_cnt >= V_ACT_S) && (v_cnt < V_ACT_E);
    de     = busy && h_vis && v_vis;
  end

`ifdef VGA_SYNC_ACTIVE_LOW_EN
  assign o_vga_hsync = !hs_act;
  assign o_vga_vsync = !vs_act;
`else
  assign o_vga_hsync = hs_act;
  assign o_vga_vsync = vs_act;
`endif

  assign o_px_en       = px_en;
  assign o_de          = de;
  assign o_x           = de ? (h_cnt - H_ACT_S) : '0;
  assign o_y           = de ? (v_cnt - V_ACT_S) : '0;
  assign o_frame_start = px_en && (h_cnt == '0) && (v_cnt == '0);
  assign o_busy        = busy;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl: two small-timing instances (PX_DIV=3 and 1) checked
// against a tick-count reference model of the frame.
module tb_vga_timing_ctrl;

  localparam int HS = 4, HBP = 3, HA = 8, HFP = 2;
  localparam int VS = 2, VBP = 2, VA = 5, VFP = 1;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int W  = 10;

  logic clk = 1'b0, i_rst = 1'b1, i_run = 1'b0;
  logic a_pe, a_hs, a_vs, a_de, a_fs, a_bz;
  logic b_pe, b_hs, b_vs, b_de, b_fs, b_bz;
  logic [W-1:0] a_x, a_y, b_x, b_y;

  int checks = 0, errors = 0;
  bit m_busy[2], m_drain[2];
  int m_t[2], fs_obs[2], fs_mod[2];
  int max_x = 0, max_y = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl #(.PX_DIV(3), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP), .CNT_W(W)) u_dut_a (
    .clk(clk), .i_rst(i_rst), .i_run(i_run), .o_px_en(a_pe), .o_vga_hsync(a_hs),
    .o_vga_vsync(a_vs), .o_de(a_de), .o_x(a_x), .o_y(a_y), .o_frame_start(a_fs), .o_busy(a_bz));

  vga_timing_ctrl #(.PX_DIV(1), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP), .CNT_W(W)) u_dut_b (
    .clk(clk), .i_rst(i_rst), .i_run(i_run), .o_px_en(b_pe), .o_vga_hsync(b_hs),
    .o_vga_vsync(b_vs), .o_de(b_de), .o_x(b_x), .o_y(b_y), .o_frame_start(b_fs), .o_busy(b_bz));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int divof(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  // Expected outputs follow from (busy, clocks since frame start): pixel = t/div, h/v by mod/div.
  task automatic check_dut(input int k, input logic pe, input logic hs, input logic vs,
                           input logic de, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic fs, input logic bz);
    int d, pix, h, v, ex, ey;
    logic epe, ehs, evs, ede, efs;
    string nm;
    nm  = (k == 0) ? "a" : "b";
    d   = divof(k);
    pix = m_t[k] / d;
    h   = pix % HT;
    v   = pix / HT;
    epe = m_busy[k] && (m_t[k] % d == d - 1);
    ehs = m_busy[k] && (h < HS);
    evs = m_busy[k] && (v < VS);
    ede = m_busy[k] && (h >= HS + HBP) && (h < HS + HBP + HA) && (v >= VS + VBP) && (v < VS + VBP + VA);
    ex  = ede ? h - (HS + HBP) : 0;
    ey  = ede ? v - (VS + VBP) : 0;
    efs = epe && (pix == 0);
`ifdef VGA_SYNC_ACTIVE_LOW_EN
    ehs = !ehs;
    evs = !evs;
`endif
    chk({nm, "_px_en"}, {31'b0, pe}, {31'b0, epe});
    chk({nm, "_hsync"}, {31'b0, hs}, {31'b0, ehs});
    chk({nm, "_vsync"}, {31'b0, vs}, {31'b0, evs});
    chk({nm, "_de"}, {31'b0, de}, {31'b0, ede});
    chk({nm, "_x"}, {22'b0, x}, ex);
    chk({nm, "_y"}, {22'b0, y}, ey);
    chk({nm, "_frame_start"}, {31'b0, fs}, {31'b0, efs});
    chk({nm, "_busy"}, {31'b0, bz}, {31'b0, m_busy[k]});
    if (fs === 1'b1) fs_obs[k]++;
    if (efs) fs_mod[k]++;
    if (k == 0 && de === 1'b1) begin
      if (int'(x) > max_x) max_x = int'(x);
      if (int'(y) > max_y) max_y = int'(y);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; m_drain[k] = 1'b0; m_t[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int d, pix;
    bit pe, last;
    d    = divof(k);
    pix  = m_t[k] / d;
    pe   = m_busy[k] && (m_t[k] % d == d - 1);
    last = pe && (pix == HT * VT - 1);
    if (i_rst) begin
      m_busy[k] = 1'b0; m_drain[k] = 1'b0; m_t[k] = 0;
    end else if (!m_busy[k]) begin
      if (i_run) begin m_busy[k] = 1'b1; m_drain[k] = 1'b0; end
      m_t[k] = 0;
    end else begin
      if (i_run)           m_drain[k] = 1'b0;
      else if (!m_drain[k]) m_drain[k] = 1'b1;
      else if (last)       m_busy[k] = 1'b0;
      m_t[k] = m_busy[k] ? (m_t[k] + 1) % (d * HT * VT) : 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_dut(0, a_pe, a_hs, a_vs, a_de, a_x, a_y, a_fs, a_bz);
    check_dut(1, b_pe, b_hs, b_vs, b_de, b_x, b_y, b_fs, b_bz);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  // Reset lands between edges; outputs must clear before the next clock.
  task automatic async_rst();
    #2 i_rst = 1'b1;
    #1;
    model_reset();
    check_dut(0, a_pe, a_hs, a_vs, a_de, a_x, a_y, a_fs, a_bz);
    check_dut(1, b_pe, b_hs, b_vs, b_de, b_x, b_y, b_fs, b_bz);
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic wait_line(input int line, input int budget);
    int n = 0;
    while (!(m_busy[0] && (m_t[0] / 3) / HT == line) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_line_timeout", {31'b0, n >= budget}, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((a_bz !== 1'b0 || b_bz !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle_timeout", {31'b0, n >= budget}, 0);
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    i_rst = 1'b0;
    repeat (3) tick();

    i_run = 1'b1;
    repeat (2 * 3 * HT * VT + 100) tick();

    wait_line(3, 2000);
    i_run = 1'b0;
    wait_idle(2000);
    chk("a_frames_after_drain", fs_obs[0], fs_mod[0]);
    chk("b_frames_after_drain", fs_obs[1], fs_mod[1]);

    i_run = 1'b1;
    tick();
    wait_line(8, 2000);
    i_run = 1'b0;
    repeat (40) tick();
    i_run = 1'b1;
    repeat (600) tick();

    wait_line(4, 2000);
    repeat (5) tick();
    i_run = 1'b0;
    async_rst();
    repeat (10) tick();
    i_run = 1'b1;
    repeat (300) tick();

    repeat (8000) begin
      if ($urandom_range(0, 299) == 0) i_run = ~i_run;
      if ($urandom_range(0, 2999) == 0) async_rst();
      tick();
    end

    i_run = 1'b0;
    wait_idle(2000);
    repeat (5) tick();
    chk("a_frame_count", fs_obs[0], fs_mod[0]);
    chk("b_frame_count", fs_obs[1], fs_mod[1]);
    chk("a_last_x", max_x, HA - 1);
    chk("a_last_y", max_y, VA - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Frame-level VGA timing controller. It derives the pixel-clock enable from the system clock, sequences the horizontal and vertical counters through sync, back porch, active and front porch, and produces sync, data-enable and pixel coordinates for the pixel generator. A run/stop FSM starts output cleanly and only ever stops it at a frame boundary.

Parameters:
PX_DIV, 4, system clocks per pixel (≥1; 100 MHz→25 MHz)
H_SYNC, 96, hsync width in pixels
H_BP, 48, horizontal back porch
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
V_SYNC, 2, vsync width in lines
V_BP, 33, vertical back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
CNT_W, 10, counter/coordinate width

Ports:
clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_run  in  1  level request to generate frames
o_px_en  out  1  pixel-clock enable, one clk wide
o_vga_hsync  out  1  horizontal sync
o_vga_vsync  out  1  vertical sync
o_de  out  1  active-video flag
o_x  out  CNT_W  active pixel column, 0..H_ACTIVE-1
o_y  out  CNT_W  active pixel row, 0..V_ACTIVE-1
o_frame_start  out  1  one-clk pulse at the end of pixel period (h=0, v=0)
o_busy  out  1  state != IDLE

Behaviour:
- One clock domain, clk. i_rst is asynchronous and active-high. Reset forces state IDLE, the divider and both counters to 0, and all outputs to 0 (syncs inactive).
- Totals: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Divider: counts 0..PX_DIV-1 only while busy. o_px_en=1 when div==PX_DIV-1. PX_DIV=1 gives o_px_en=1 on every busy cycle.
- h_cnt increments on o_px_en. At H_TOTAL-1 it wraps to 0, and v_cnt increments. v_cnt wraps at V_TOTAL-1.
- Line and frame order both start with sync at count 0:
  - Horizontal: sync [0,H_SYNC), back porch, active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE), front porch.
  - Vertical uses the same order.
- All outputs decode combinationally from registered counters and state, so they have zero latency relative to the counters. All are 0 in IDLE.
  - o_vga_hsync = busy & h_cnt<H_SYNC.
  - o_vga_vsync = busy & v_cnt<V_SYNC.
  - o_de = busy & h in active & v in active.
  - o_x = h_cnt-(H_SYNC+H_BP) and o_y = v_cnt-(V_SYNC+V_BP) when o_de; otherwise 0.
  - o_frame_start = o_px_en & h_cnt==0 & v_cnt==0.
- FSM:
  - IDLE: counters and divider held at 0. If i_run=1 → RUN on the next edge.
  - RUN: counting. If i_run=0 → DRAIN.
  - DRAIN: counting continues. On o_px_en with h=H_TOTAL-1 and v=V_TOTAL-1 → IDLE, with counters left at 0. If i_run=1 → RUN, counters undisturbed.
  - If i_run drops on the same cycle as the last-pixel px_en while in RUN, go to DRAIN. The next frame is then drained in full. Frames are never truncated.
- First o_px_en occurs PX_DIV clks after the edge that enters RUN.
- i_rst asserted mid-frame: immediate IDLE, all outputs 0 without waiting for the clock. After release, restart requires i_run.

Optional Feature:
Macro VGA_SYNC_ACTIVE_LOW_EN.
- Defined: o_vga_hsync and o_vga_vsync are inverted, i.e. active-low and idle/reset level 1 (standard 640x480 polarity).
- Undefined: syncs are active-high and idle/reset level 0.
- o_de, coordinates and all other outputs are unaffected either way.

Decomposition:
- Package vga_timing_pkg:
  - CNT_W
  - the 640x480@60 timing constants (defaults above)
  - derived H_TOTAL/V_TOTAL and active start/end bounds
  - FSM state encoding (IDLE, RUN, DRAIN)
- Sub-module vga_axis_cnt holds one axis counter:
  - parameters TOTAL and width
  - inputs clk, i_rst, i_clr, i_en
  - outputs o_cnt and o_wrap (i_en & cnt==TOTAL-1)
  - instantiated twice; the horizontal o_wrap drives the vertical i_en.

Test Plan:
- Reset mid-RUN (h=300, v=100), i_rst asynchronous between edges → outputs 0 and o_busy=0 before the next edge; counters 0.
- i_run rises, defaults → o_px_en every 4th clk, first one 4 clks after RUN entry; o_vga_hsync high for exactly 96 px_en periods, period 800.
- Full frame → o_vga_vsync high for exactly 2 lines; o_de=1 for 640x480=307200 px_en cycles; first o_de pixel at h=144, v=35 shows o_x=0, o_y=0; last pixel shows o_x=639, o_y=479.
- i_run dropped at v=200 → frame completes to h=799/v=524, then IDLE; o_frame_start count equals frames started; no partial frame.
- In DRAIN at v=400, i_run re-asserted → RUN with no counter discontinuity; the next frame starts at o_frame_start with correct timing.
- PX_DIV=1, VGA_SYNC_ACTIVE_LOW_EN defined → o_px_en constantly 1 while busy; syncs 1 in reset/IDLE and low for 96 clks per line.
